wrr_arbiter: RTL and testbench

//  Parametrised weighted round-robin arbiter with registered, held grants.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 29 ++
 rtl/wrr_arbiter.sv | 88 ++++++++
 tb/tb_wrr_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Index width that stays at least 1 bit wide for tiny requester counts.
  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational cyclic-priority picker: first set req bit at or after the one-hot pointer.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = idw_of(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   pointer,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] index
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_gnt;

  // Upper copy of req lets the search wrap past bit N-1 back to bit 0.
  assign w_dbl = {req, req};
  assign w_gnt = w_dbl & ~(w_dbl - {{N{1'b0}}, pointer});
  assign pick  = w_gnt[N-1:0] | w_gnt[2*N-1:N];

  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick[i]) index = IDW'(i);
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to WEIGHT acks per owner.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int WW  = 3,
  localparam int IDW = idw_of(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            ack,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id
);

  arb_state_t     r_state;
  logic [N-1:0]   r_grant;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_ptr;
  logic [WW:0]    r_count;
  logic [WW-1:0]  r_eff_w;

  logic           w_release;
  logic           w_search;
  logic [IDW-1:0] w_next_ptr;
  logic [IDW-1:0] w_search_ptr;
  logic [N-1:0]   w_ptr_onehot;
  logic [N-1:0]   w_pick;
  logic [IDW-1:0] w_pick_idx;
  logic [WW-1:0]  w_pick_weight;
  logic [WW-1:0]  w_pick_eff;

  assign w_next_ptr = (r_owner == IDW'(N - 1)) ? '0 : r_owner + 1'b1;

  assign w_release = (r_state == HOLD) &&
                     ((ack && ((r_count + 1'b1) == {1'b0, r_eff_w})) || !req[r_owner]);

  // On release the search starts just past the owner, so the owner is considered last.
  assign w_search     = (r_state == IDLE) || w_release;
  assign w_search_ptr = w_release ? w_next_ptr : r_ptr;
  assign w_ptr_onehot = {{(N-1){1'b0}}, 1'b1} << w_search_ptr;

  rr_priority_pick #(.N(N)) u_pick (
    .req     (req),
    .pointer (w_ptr_onehot),
    .pick    (w_pick),
    .index   (w_pick_idx)
  );

  assign w_pick_weight = weight[w_pick_idx*WW +: WW];
  assign w_pick_eff    = (w_pick_weight == '0) ? WW'(1) : w_pick_weight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_eff_w <= '0;
    end else begin
      if (w_release) r_ptr <= w_next_ptr;
      if (w_search) begin
        r_count <= '0;
        if (|req) begin
          r_state <= HOLD;
          r_grant <= w_pick;
          r_owner <= w_pick_idx;
          r_eff_w <= w_pick_eff;
        end else begin
          r_state <= IDLE;
          r_grant <= '0;
          r_owner <= '0;
        end
      end else if (ack) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_id    = r_owner;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter (N=4, WW=3): vector table plus reset corner sequences.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*WW-1:0] weight;
  logic          ack;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [1:0]    grant_id;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] weight;
    logic        ack;
    logic [3:0]  exp_grant;
    int          exp_id;
  } vec_t;

  vec_t vecs[$];

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] w4(input int w3, input int w2, input int w1, input int w0);
    return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eg, input int eid);
    check({tag, " grant"}, int'(grant), int'(eg));
    check({tag, " valid"}, int'(grant_valid), (eg != 4'b0000) ? 1 : 0);
    check({tag, " id"}, int'(grant_id), eid);
  endtask

  task automatic add(input logic [3:0] r, input logic [11:0] w, input logic a,
                     input logic [3:0] eg, input int eid);
    vec_t v;
    v.req = r; v.weight = w; v.ack = a; v.exp_grant = eg; v.exp_id = eid;
    vecs.push_back(v);
  endtask

  initial begin
    logic [11:0] wa, wb, wc, wd;
    n_checks = 0;
    n_fail   = 0;
    wa = w4(1, 1, 1, 1);
    wb = w4(1, 1, 1, 3);
    wc = w4(1, 1, 1, 0);
    wd = w4(1, 2, 1, 0);

    // Plain rotation, weight 1 each
    add(4'b1111, wa, 1, 4'b0010, 1);
    add(4'b1111, wa, 1, 4'b0100, 2);
    add(4'b1111, wa, 1, 4'b1000, 3);
    add(4'b1111, wa, 1, 4'b0001, 0);
    add(4'b1111, wa, 1, 4'b0010, 1);
    // Requester 0 weighted 3
    add(4'b1111, wb, 1, 4'b0100, 2);
    add(4'b1111, wb, 1, 4'b1000, 3);
    add(4'b1111, wb, 1, 4'b0001, 0);
    add(4'b1111, wb, 1, 4'b0001, 0);
    add(4'b1111, wb, 1, 4'b0001, 0);
    add(4'b1111, wb, 1, 4'b0010, 1);
    add(4'b1111, wb, 1, 4'b0100, 2);
    add(4'b1111, wb, 1, 4'b1000, 3);
    add(4'b1111, wb, 1, 4'b0001, 0);
    add(4'b1111, wb, 1, 4'b0001, 0);
    add(4'b1111, wb, 1, 4'b0001, 0);
    add(4'b1111, wb, 1, 4'b0010, 1);
    // Weight 0 behaves as 1
    add(4'b1111, wc, 1, 4'b0100, 2);
    add(4'b1111, wc, 1, 4'b1000, 3);
    add(4'b1111, wc, 1, 4'b0001, 0);
    add(4'b1111, wc, 1, 4'b0010, 1);
    add(4'b1111, wc, 1, 4'b0100, 2);
    add(4'b1111, wc, 1, 4'b1000, 3);
    // Owner 3 abandons without ack: pointer wraps to 0
    add(4'b0101, wc, 0, 4'b0001, 0);
    // ack and req drop together: single release
    add(4'b0100, wc, 1, 4'b0100, 2);
    // Lone requester 2 with weight 2: back-to-back regrants
    add(4'b0100, wd, 1, 4'b0100, 2);
    add(4'b0100, wd, 1, 4'b0100, 2);
    add(4'b0100, wd, 1, 4'b0100, 2);
    add(4'b0100, wd, 1, 4'b0100, 2);
    add(4'b0100, wd, 1, 4'b0100, 2);
    add(4'b0100, wd, 0, 4'b0100, 2);
    add(4'b0100, wd, 1, 4'b0100, 2);
    add(4'b1100, wd, 1, 4'b1000, 3);
    // Non-owner req changes do not disturb the grant
    add(4'b1111, wd, 0, 4'b1000, 3);
    add(4'b1011, wd, 0, 4'b1000, 3);
    // Drop to idle, ack ignored while idle, regrant from pointer 0
    add(4'b0000, wd, 0, 4'b0000, 0);
    add(4'b0000, wd, 1, 4'b0000, 0);
    add(4'b0010, wd, 0, 4'b0010, 1);
    add(4'b1111, wa, 0, 4'b0010, 1);

    // Reset held with all requests asserted
    rst_n  = 1'b0;
    req    = 4'b1111;
    weight = wa;
    ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outs("reset", 4'b0000, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check_outs("first_grant", 4'b0001, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req    = vecs[i].req;
      weight = vecs[i].weight;
      ack    = vecs[i].ack;
      @(posedge clk);
      #1 check_outs($sformatf("row%0d", i), vecs[i].exp_grant, vecs[i].exp_id);
    end

    // Asynchronous reset while owner 1 holds the grant
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 4'b0000, 0);
    req = 4'b1111;
    ack = 1'b0;
    @(posedge clk);
    #1 check_outs("in_rst", 4'b0000, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check_outs("post_rst", 4'b0001, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
